// File: rtl/crossbar_skid_param.sv
// Action-stage crossbar: decodes one action word per PHV container into ALU operand
// buses, registered through a two-slot (output + skid) valid/ready buffer.
module crossbar_skid_param #(
  parameter int unsigned NUM_PER_TYPE = 8,
  parameter int unsigned W6           = 48,
  parameter int unsigned W4           = 32,
  parameter int unsigned W2           = 16,
  parameter int unsigned META_W       = 256,
  parameter int unsigned ACT_LEN      = 25,
  parameter int unsigned NUM_ACT      = 3 * NUM_PER_TYPE + 1,
  parameter int unsigned PHV_LEN      = NUM_PER_TYPE * (W6 + W4 + W2) + META_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PHV_LEN-1:0]         phv_in,
  input  logic [ACT_LEN*NUM_ACT-1:0] action_in,
  input  logic                       in_valid,
  output logic                       ready_out,
  output logic                       alu_in_valid,
  output logic [W6*NUM_PER_TYPE-1:0] alu_in_6B_1,
  output logic [W6*NUM_PER_TYPE-1:0] alu_in_6B_2,
  output logic [W4*NUM_PER_TYPE-1:0] alu_in_4B_1,
  output logic [W4*NUM_PER_TYPE-1:0] alu_in_4B_2,
  output logic [W4*NUM_PER_TYPE-1:0] alu_in_4B_3,
  output logic [W2*NUM_PER_TYPE-1:0] alu_in_2B_1,
  output logic [W2*NUM_PER_TYPE-1:0] alu_in_2B_2,
  output logic [META_W-1:0]          phv_remain_data,
  output logic [ACT_LEN*NUM_ACT-1:0] action_out,
  input  logic                       ready_in
);

  localparam int unsigned N     = NUM_PER_TYPE;
  localparam int unsigned SEL_W = $clog2(NUM_PER_TYPE);
  localparam int unsigned BASE4 = META_W + N * W2;
  localparam int unsigned BASE6 = BASE4 + N * W4;

  typedef struct packed {
    logic [W6*N-1:0]            a6;
    logic [W6*N-1:0]            b6;
    logic [W4*N-1:0]            a4;
    logic [W4*N-1:0]            b4;
    logic [W4*N-1:0]            c4;
    logic [W2*N-1:0]            a2;
    logic [W2*N-1:0]            b2;
    logic [META_W-1:0]          meta;
    logic [ACT_LEN*NUM_ACT-1:0] act;
  } beat_t;

  logic [W6-1:0] cont6 [N];
  logic [W4-1:0] cont4 [N];
  logic [W2-1:0] cont2 [N];

  for (genvar i = 0; i < N; i++) begin : g_cont
    assign cont6[i] = phv_in[BASE6 + i*W6 +: W6];
    assign cont4[i] = phv_in[BASE4 + i*W4 +: W4];
    assign cont2[i] = phv_in[META_W + i*W2 +: W2];
  end

  logic [W6*N-1:0] dec_6b_1, dec_6b_2;
  logic [W4*N-1:0] dec_4b_1, dec_4b_2, dec_4b_3;
  logic [W2*N-1:0] dec_2b_1, dec_2b_2;

  // 6B decode; an index beyond N-1 (non power-of-two N) selects zero
  always_comb begin
    logic [3:0]       op;
    logic [SEL_W-1:0] ia, ib;
    logic [15:0]      imm;
    logic [W6-1:0]    ca, cb;
    dec_6b_1 = '0;
    dec_6b_2 = '0;
    for (int i = 0; i < N; i++) begin
      op  = action_in[ACT_LEN*(2*N+1+i) + 21 +: 4];
      ia  = action_in[ACT_LEN*(2*N+1+i) + 16 +: SEL_W];
      ib  = action_in[ACT_LEN*(2*N+1+i) + 11 +: SEL_W];
      imm = action_in[ACT_LEN*(2*N+1+i) +: 16];
      ca  = '0;
      cb  = '0;
      for (int j = 0; j < N; j++) begin
        if (ia == SEL_W'(j)) ca = cont6[j];
        if (ib == SEL_W'(j)) cb = cont6[j];
      end
      case (op)
        4'b0001, 4'b0010: begin dec_6b_1[i*W6 +: W6] = ca; dec_6b_2[i*W6 +: W6] = cb; end
        4'b1001, 4'b1010: begin dec_6b_1[i*W6 +: W6] = ca; dec_6b_2[i*W6 +: W6] = W6'(imm); end
        4'b1110:          begin dec_6b_1[i*W6 +: W6] = '0; dec_6b_2[i*W6 +: W6] = W6'(imm); end
        default:          begin dec_6b_1[i*W6 +: W6] = cont6[i]; dec_6b_2[i*W6 +: W6] = '0; end
      endcase
    end
  end

  // 4B decode: shared ops plus the 4B-only ops and the split-immediate C operand
  always_comb begin
    logic [3:0]       op;
    logic [4:0]       a5;
    logic [SEL_W-1:0] ib;
    logic [15:0]      imm;
    logic [W4-1:0]    ca, cb;
    dec_4b_1 = '0;
    dec_4b_2 = '0;
    dec_4b_3 = '0;
    for (int i = 0; i < N; i++) begin
      op  = action_in[ACT_LEN*(N+1+i) + 21 +: 4];
      a5  = action_in[ACT_LEN*(N+1+i) + 16 +: 5];
      ib  = action_in[ACT_LEN*(N+1+i) + 11 +: SEL_W];
      imm = action_in[ACT_LEN*(N+1+i) +: 16];
      ca  = '0;
      cb  = '0;
      for (int j = 0; j < N; j++) begin
        if (a5[SEL_W-1:0] == SEL_W'(j)) ca = cont4[j];
        if (ib == SEL_W'(j))            cb = cont4[j];
      end
      dec_4b_3[i*W4 +: W4] = cont4[i];
      case (op)
        4'b0001, 4'b0010, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1011: begin
          dec_4b_1[i*W4 +: W4] = ca;
          dec_4b_2[i*W4 +: W4] = cb;
        end
        4'b1001, 4'b1010: begin dec_4b_1[i*W4 +: W4] = ca; dec_4b_2[i*W4 +: W4] = W4'(imm); end
        4'b1110:          begin dec_4b_1[i*W4 +: W4] = '0; dec_4b_2[i*W4 +: W4] = W4'(imm); end
        4'b0011:          begin dec_4b_1[i*W4 +: W4] = W4'(a5); dec_4b_2[i*W4 +: W4] = W4'(imm); end
        4'b0100: begin
          dec_4b_1[i*W4 +: W4] = ca;
          dec_4b_2[i*W4 +: W4] = W4'(imm[13:11]);
          dec_4b_3[i*W4 +: W4] = W4'(imm[10:0]);
        end
        default:          begin dec_4b_1[i*W4 +: W4] = cont4[i]; dec_4b_2[i*W4 +: W4] = '0; end
      endcase
    end
  end

  // 2B decode; shared ops only
  always_comb begin
    logic [3:0]       op;
    logic [SEL_W-1:0] ia, ib;
    logic [15:0]      imm;
    logic [W2-1:0]    ca, cb;
    dec_2b_1 = '0;
    dec_2b_2 = '0;
    for (int i = 0; i < N; i++) begin
      op  = action_in[ACT_LEN*(1+i) + 21 +: 4];
      ia  = action_in[ACT_LEN*(1+i) + 16 +: SEL_W];
      ib  = action_in[ACT_LEN*(1+i) + 11 +: SEL_W];
      imm = action_in[ACT_LEN*(1+i) +: 16];
      ca  = '0;
      cb  = '0;
      for (int j = 0; j < N; j++) begin
        if (ia == SEL_W'(j)) ca = cont2[j];
        if (ib == SEL_W'(j)) cb = cont2[j];
      end
      case (op)
        4'b0001, 4'b0010: begin dec_2b_1[i*W2 +: W2] = ca; dec_2b_2[i*W2 +: W2] = cb; end
        4'b1001, 4'b1010: begin dec_2b_1[i*W2 +: W2] = ca; dec_2b_2[i*W2 +: W2] = W2'(imm); end
        4'b1110:          begin dec_2b_1[i*W2 +: W2] = '0; dec_2b_2[i*W2 +: W2] = W2'(imm); end
        default:          begin dec_2b_1[i*W2 +: W2] = cont2[i]; dec_2b_2[i*W2 +: W2] = '0; end
      endcase
    end
  end

  beat_t dec, o_q, o_d, s_q, s_d;
  logic  o_valid_q, o_valid_d, s_full_q, s_full_d;
  logic  accept;

  assign dec = {dec_6b_1, dec_6b_2, dec_4b_1, dec_4b_2, dec_4b_3, dec_2b_1, dec_2b_2,
                phv_in[META_W-1:0], action_in};

  assign ready_out = !s_full_q;
  assign accept    = in_valid && ready_out;

  // Slot steering: O refills from S first, otherwise from an accepted beat; S only fills
  // while O is held, which also blocks new accepts until S drains.
  always_comb begin
    o_d       = o_q;
    s_d       = s_q;
    o_valid_d = o_valid_q;
    s_full_d  = s_full_q;
    if (!o_valid_q || ready_in) begin
      if (s_full_q) begin
        o_d       = s_q;
        o_valid_d = 1'b1;
        s_full_d  = 1'b0;
      end else if (accept) begin
        o_d       = dec;
        o_valid_d = 1'b1;
      end else begin
        o_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_d      = dec;
      s_full_d = 1'b1;
    end
  end

  // Slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q       <= '0;
      s_q       <= '0;
      o_valid_q <= 1'b0;
      s_full_q  <= 1'b0;
    end else begin
      o_q       <= o_d;
      s_q       <= s_d;
      o_valid_q <= o_valid_d;
      s_full_q  <= s_full_d;
    end
  end

  assign alu_in_valid    = o_valid_q;
  assign alu_in_6B_1     = o_q.a6;
  assign alu_in_6B_2     = o_q.b6;
  assign alu_in_4B_1     = o_q.a4;
  assign alu_in_4B_2     = o_q.b4;
  assign alu_in_4B_3     = o_q.c4;
  assign alu_in_2B_1     = o_q.a2;
  assign alu_in_2B_2     = o_q.b2;
  assign phv_remain_data = o_q.meta;
  assign action_out      = o_q.act;

endmodule

// File: tb/tb_crossbar_skid_param.sv
// Scoreboard bench for crossbar_skid_param: an 8-container instance for most tests and a
// 16-container instance for the wide-index case.
module tb_crossbar_skid_param;

  // Beats and expectations are held at the 16-container size; the 8-container instance uses
  // the low part of each field, so zero-extended DUT outputs line up directly.
  typedef struct packed {
    logic [767:0]  c6;
    logic [511:0]  c4;
    logic [255:0]  c2;
    logic [255:0]  meta;
    logic [1224:0] act;
  } beat_t;

  typedef struct packed {
    logic [767:0]  a6, b6;
    logic [511:0]  a4, b4, c4;
    logic [255:0]  a2, b2;
    logic [255:0]  meta;
    logic [1224:0] act;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  beat_t b8 = '0, b16 = '0;
  logic vld8 = 1'b0, vld16 = 1'b0, rin8, rin16 = 1'b1;
  logic rdy8, rdy16, ov8, ov16;
  logic [1023:0] phv8;
  logic [1791:0] phv16;
  logic [624:0]  act8, o8_act;
  logic [1224:0] act16, o16_act;
  logic [383:0]  o8_a6, o8_b6;
  logic [255:0]  o8_a4, o8_b4, o8_c4;
  logic [127:0]  o8_a2, o8_b2;
  logic [255:0]  o8_meta;
  logic [767:0]  o16_a6, o16_b6;
  logic [511:0]  o16_a4, o16_b4, o16_c4;
  logic [255:0]  o16_a2, o16_b2;
  logic [255:0]  o16_meta;

  assign phv8  = {b8.c6[383:0], b8.c4[255:0], b8.c2[127:0], b8.meta};
  assign act8  = b8.act[624:0];
  assign phv16 = {b16.c6, b16.c4, b16.c2, b16.meta};
  assign act16 = b16.act;

  crossbar_skid_param #(.NUM_PER_TYPE(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .phv_in(phv8), .action_in(act8), .in_valid(vld8),
    .ready_out(rdy8), .alu_in_valid(ov8), .alu_in_6B_1(o8_a6), .alu_in_6B_2(o8_b6),
    .alu_in_4B_1(o8_a4), .alu_in_4B_2(o8_b4), .alu_in_4B_3(o8_c4), .alu_in_2B_1(o8_a2),
    .alu_in_2B_2(o8_b2), .phv_remain_data(o8_meta), .action_out(o8_act), .ready_in(rin8)
  );

  crossbar_skid_param #(.NUM_PER_TYPE(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .phv_in(phv16), .action_in(act16), .in_valid(vld16),
    .ready_out(rdy16), .alu_in_valid(ov16), .alu_in_6B_1(o16_a6), .alu_in_6B_2(o16_b6),
    .alu_in_4B_1(o16_a4), .alu_in_4B_2(o16_b4), .alu_in_4B_3(o16_c4), .alu_in_2B_1(o16_a2),
    .alu_in_2B_2(o16_b2), .phv_remain_data(o16_meta), .action_out(o16_act), .ready_in(rin16)
  );

  exp_t q8[$], q16[$];
  int   checks = 0, errors = 0;
  bit   rand_rdy = 1'b0, rdy_hold = 1'b1;

  task automatic chk(string name, logic [1224:0] got, logic [1224:0] want);
    int k = 0;
    checks++;
    if (got !== want) begin
      errors++;
      for (int i = 0; i < 1225; i++) if (got[i] !== want[i]) begin k = i; break; end
      if (k > 1193) k = 1193;
      $display("FAIL %s bit %0d: got %h expected %h (32b window)", name, k, got[k +: 32],
               want[k +: 32]);
    end
  endtask

  task automatic cmp(string tag, exp_t g, exp_t e);
    chk({tag, "_6B_1"}, 1225'(g.a6), 1225'(e.a6));
    chk({tag, "_6B_2"}, 1225'(g.b6), 1225'(e.b6));
    chk({tag, "_4B_1"}, 1225'(g.a4), 1225'(e.a4));
    chk({tag, "_4B_2"}, 1225'(g.b4), 1225'(e.b4));
    chk({tag, "_4B_3"}, 1225'(g.c4), 1225'(e.c4));
    chk({tag, "_2B_1"}, 1225'(g.a2), 1225'(e.a2));
    chk({tag, "_2B_2"}, 1225'(g.b2), 1225'(e.b2));
    chk({tag, "_meta"}, 1225'(g.meta), 1225'(e.meta));
    chk({tag, "_act"}, g.act, e.act);
  endtask

  function automatic exp_t get8();
    exp_t g = '0;
    g.a6 = 768'(o8_a6); g.b6 = 768'(o8_b6);
    g.a4 = 512'(o8_a4); g.b4 = 512'(o8_b4); g.c4 = 512'(o8_c4);
    g.a2 = 256'(o8_a2); g.b2 = 256'(o8_b2);
    g.meta = o8_meta;   g.act = 1225'(o8_act);
    return g;
  endfunction

  function automatic exp_t get16();
    exp_t g;
    g.a6 = o16_a6; g.b6 = o16_b6; g.a4 = o16_a4; g.b4 = o16_b4; g.c4 = o16_c4;
    g.a2 = o16_a2; g.b2 = o16_b2; g.meta = o16_meta; g.act = o16_act;
    return g;
  endfunction

  function automatic logic [47:0] getc(beat_t b, int t, int j);
    if (t == 0) return 48'(b.c2[j*16 +: 16]);
    if (t == 1) return 48'(b.c4[j*32 +: 32]);
    return b.c6[j*48 +: 48];
  endfunction

  // Reference decode used for random traffic
  function automatic exp_t model(beat_t b, int n);
    exp_t e = '0;
    logic [24:0] w;
    logic [47:0] va, vb, vc, ca, cb, ci;
    e.meta = b.meta;
    e.act  = b.act;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < n; i++) begin
        w  = b.act[25*(1 + t*n + i) +: 25];
        ca = getc(b, t, int'(w[20:16]) % n);
        cb = getc(b, t, int'(w[15:11]) % n);
        ci = getc(b, t, i);
        va = ci; vb = '0; vc = ci;
        case (w[24:21])
          4'd1, 4'd2:  begin va = ca; vb = cb; end
          4'd9, 4'd10: begin va = ca; vb = 48'(w[15:0]); end
          4'd14:       begin va = '0; vb = 48'(w[15:0]); end
          4'd5, 4'd6, 4'd7, 4'd8, 4'd11: if (t == 1) begin va = ca; vb = cb; end
          4'd3: if (t == 1) begin va = 48'(w[20:16]); vb = 48'(w[15:0]); end
          4'd4: if (t == 1) begin va = ca; vb = 48'(w[13:11]); vc = 48'(w[10:0]); end
          default: ;
        endcase
        if (t == 0) begin e.a2[i*16 +: 16] = va[15:0]; e.b2[i*16 +: 16] = vb[15:0]; end
        if (t == 1) begin
          e.a4[i*32 +: 32] = va[31:0]; e.b4[i*32 +: 32] = vb[31:0]; e.c4[i*32 +: 32] = vc[31:0];
        end
        if (t == 2) begin e.a6[i*48 +: 48] = va; e.b6[i*48 +: 48] = vb; end
      end
    end
    return e;
  endfunction

  // Expectation when every word decodes as "other": own container on A (and C), zero on B
  function automatic exp_t passthru(beat_t b, int n);
    exp_t e = '0;
    e.meta = b.meta;
    e.act  = b.act;
    for (int i = 0; i < n; i++) begin
      e.a6[i*48 +: 48] = b.c6[i*48 +: 48];
      e.a4[i*32 +: 32] = b.c4[i*32 +: 32];
      e.c4[i*32 +: 32] = b.c4[i*32 +: 32];
      e.a2[i*16 +: 16] = b.c2[i*16 +: 16];
    end
    return e;
  endfunction

  function automatic beat_t mkbeat(int n, int s);
    beat_t b = '0;
    for (int i = 0; i < n; i++) begin
      b.c6[i*48 +: 48] = {16'h6600 + 16'(s), 16'(i), 16'h0600 + 16'(i)};
      b.c4[i*32 +: 32] = {16'h4400 + 16'(s), 16'h0400 + 16'(i)};
      b.c2[i*16 +: 16] = {8'h20 + 8'(s), 8'(i)};
    end
    b.meta = {224'h0, 32'hDEAD_0000 + 32'(s)};
    b.act[24:0] = 25'h1AB_0000 + 25'(s);
    return b;
  endfunction

  function automatic beat_t randbeat(int n);
    beat_t b = '0;
    for (int i = 0; i < n; i++) begin
      b.c6[i*48 +: 48] = 48'({$urandom(), $urandom()});
      b.c4[i*32 +: 32] = $urandom();
      b.c2[i*16 +: 16] = 16'($urandom());
    end
    for (int j = 0; j < 8; j++) b.meta[j*32 +: 32] = $urandom();
    for (int k = 0; k < 3*n + 1; k++) b.act[k*25 +: 25] = 25'($urandom());
    return b;
  endfunction

  // Present one beat until it is accepted (bounded)
  task automatic send(int d, beat_t b, exp_t e);
    int  n = 0;
    logic acc;
    if (d == 8) begin b8 = b; vld8 = 1'b1; q8.push_back(e); end
    else begin b16 = b; vld16 = 1'b1; q16.push_back(e); end
    do begin
      @(negedge clk);
      acc = (d == 8) ? rdy8 : rdy16;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    chk($sformatf("accept_dut%0d", d), 1225'(acc), 1225'(1));
    if (d == 8) vld8 = 1'b0; else vld16 = 1'b0;
  endtask

  task automatic drain(int d);
    int n = 0;
    while (((d == 8) ? q8.size() : q16.size()) != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk($sformatf("drain_dut%0d", d), 1225'((d == 8) ? q8.size() : q16.size()), '0);
  endtask

  // ready_in driver for the 8-container instance
  initial begin
    rin8 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rin8 = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_hold;
    end
  end

  // Monitor: compare against the head of the queue while presented; pop when consumed
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ov8) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut8_extra_beat got valid=1 expected no beat");
        end else if (rin8) begin
          e = q8.pop_front();
          cmp("dut8", get8(), e);
        end else begin
          cmp("dut8_hold", get8(), q8[0]);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ov16) begin
        if (q16.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut16_extra_beat got valid=1 expected no beat");
        end else begin
          e = q16.pop_front();
          cmp("dut16", get16(), e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    exp_t  e;

    // Reset state
    #2;
    cmp("rst8", get8(), '0);
    chk("rst8_valid", 1225'(ov8), '0);
    chk("rst8_ready", 1225'(rdy8), 1225'(1));
    chk("rst16_ready", 1225'(rdy16), 1225'(1));
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T2: 6B op 0001 a=3 b=5
    b = mkbeat(8, 2);
    b.c6[3*48 +: 48] = 48'h1;
    b.c6[5*48 +: 48] = 48'h2;
    for (int i = 0; i < 8; i++) b.act[25*(17+i) +: 25] = {4'b0001, 5'd3, 5'd5, 11'd0};
    e = passthru(b, 8);
    for (int i = 0; i < 8; i++) begin
      e.a6[i*48 +: 48] = 48'h1;
      e.b6[i*48 +: 48] = 48'h2;
    end
    send(8, b, e);

    // T3: 4B op 0100 split immediate, 2B op 1110 zero/immediate
    b = mkbeat(8, 3);
    for (int i = 0; i < 8; i++) begin
      b.act[25*(9+i) +: 25] = {4'b0100, 5'd2, 2'b00, 3'd5, 11'h7FF};
      b.act[25*(1+i) +: 25] = {4'b1110, 5'd0, 16'hBEEF};
    end
    e = passthru(b, 8);
    for (int i = 0; i < 8; i++) begin
      e.a4[i*32 +: 32] = b.c4[2*32 +: 32];
      e.b4[i*32 +: 32] = 32'd5;
      e.c4[i*32 +: 32] = 32'h7FF;
      e.a2[i*16 +: 16] = 16'h0;
      e.b2[i*16 +: 16] = 16'hBEEF;
    end
    send(8, b, e);

    // 4B op 0011, 4B-only op 0101 on 6B falls to other, 2B op 1001
    b = mkbeat(8, 4);
    for (int i = 0; i < 8; i++) begin
      b.act[25*(9+i) +: 25]  = {4'b0011, 5'h1F, 16'h1234};
      b.act[25*(17+i) +: 25] = {4'b0101, 5'd1, 5'd2, 11'd0};
      b.act[25*(1+i) +: 25]  = {4'b1001, 5'd4, 16'hABCD};
    end
    e = passthru(b, 8);
    for (int i = 0; i < 8; i++) begin
      e.a4[i*32 +: 32] = 32'h1F;
      e.b4[i*32 +: 32] = 32'h1234;
      e.a2[i*16 +: 16] = b.c2[4*16 +: 16];
      e.b2[i*16 +: 16] = 16'hABCD;
    end
    send(8, b, e);
    drain(8);

    // T5: N=16, 2B op 1001 a=15; 4B/6B unlisted op 1111
    b = mkbeat(16, 5);
    for (int i = 0; i < 16; i++) begin
      b.act[25*(1+i) +: 25]  = {4'b1001, 5'd15, 16'h0042};
      b.act[25*(17+i) +: 25] = {4'b1111, 5'd3, 16'h1111};
      b.act[25*(33+i) +: 25] = {4'b1111, 5'd3, 16'h1111};
    end
    e = passthru(b, 16);
    for (int i = 0; i < 16; i++) begin
      e.a2[i*16 +: 16] = b.c2[15*16 +: 16];
      e.b2[i*16 +: 16] = 16'h0042;
    end
    send(16, b, e);
    drain(16);

    // Same word on N=8: index 15 keeps its low 3 bits -> container 7
    b = mkbeat(8, 6);
    for (int i = 0; i < 8; i++) b.act[25*(1+i) +: 25] = {4'b1001, 5'd15, 16'h0042};
    e = passthru(b, 8);
    for (int i = 0; i < 8; i++) begin
      e.a2[i*16 +: 16] = b.c2[7*16 +: 16];
      e.b2[i*16 +: 16] = 16'h0042;
    end
    send(8, b, e);
    drain(8);

    // T4: backpressure with three back-to-back beats
    rdy_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          b = mkbeat(8, 10 + k);
          b.act[25*(9+k) +: 25] = {4'b0001, 5'd1, 5'd6, 11'd0};
          e = passthru(b, 8);
          e.a4[k*32 +: 32] = b.c4[1*32 +: 32];
          e.b4[k*32 +: 32] = b.c4[6*32 +: 32];
          send(8, b, e);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        chk("bp_ready_out", 1225'(rdy8), '0);
        chk("bp_valid", 1225'(ov8), 1225'(1));
        rdy_hold = 1'b1;
      end
    join
    drain(8);

    // T1: asynchronous reset mid-stream with O and S both occupied
    rdy_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(8, mkbeat(8, 20), passthru(mkbeat(8, 20), 8));
    send(8, mkbeat(8, 21), passthru(mkbeat(8, 21), 8));
    #2 rst_n = 1'b0;
    #1;
    cmp("midrst", get8(), '0);
    chk("midrst_valid", 1225'(ov8), '0);
    chk("midrst_ready", 1225'(rdy8), 1225'(1));
    q8.delete();
    rdy_hold = 1'b1;
    #3 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("post_rst_idle", 1225'(ov8), '0);
    end
    b = mkbeat(8, 22);
    send(8, b, passthru(b, 8));
    drain(8);

    // T6: random traffic and random backpressure against the model
    rand_rdy = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      b = randbeat(8);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(8, b, model(b, 8));
    end
    rand_rdy = 1'b0;
    rdy_hold = 1'b1;
    drain(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
